// File: rtl/avalon_arbiter_if.sv
// avalon_if: Avalon-MM signal bundle with host/agent views.
//   clk, reset        : shared clock and asynchronous active-high reset
//   address/writedata : 32-bit command fields driven by the host
//   byteenable        : 4-bit write lane enables
//   burstcount        : BURSTCOUNT_W-bit burst length (0 means 1)
//   read/write        : command strobes
//   readdata          : 32-bit response data driven by the agent
//   waitrequest       : agent stall
//   readdatavalid     : response beat strobe
interface avalon_if #(
  parameter int BURSTCOUNT_W = 4
) (
  input logic clk,
  input logic reset
);
  logic [31:0]             address;
  logic [31:0]             writedata;
  logic [31:0]             readdata;
  logic [3:0]              byteenable;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic                    read;
  logic                    write;
  logic                    waitrequest;
  logic                    readdatavalid;
  modport host (
    input  clk, reset, readdata, waitrequest, readdatavalid,
    output address, writedata, byteenable, burstcount, read, write
  );
  modport agent (
    input  clk, reset, address, writedata, byteenable, burstcount, read, write,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_arbiter.sv
// avalon_arbiter: two-host Avalon-MM arbiter sharing one burst-capable agent.
//   clk       : clock
//   reset     : asynchronous active-high reset
//   avalon_h0 : requester 0 (agent view)
//   avalon_h1 : requester 1 (agent view)
//   avalon_m  : shared path to the RAM agent (host view)
// Build option AVALON_ARB_FIXED_PRIO_EN: host 0 always wins a tie instead of
// round-robin on the last owner.
module avalon_arbiter #(
  parameter int BURSTCOUNT_W = 4
) (
  input logic     clk,
  input logic     reset,
  avalon_if.agent avalon_h0,
  avalon_if.agent avalon_h1,
  avalon_if.host  avalon_m
);
  localparam int CW = BURSTCOUNT_W + 1;
  typedef enum logic [1:0] {IDLE, GRANT, WR_BURST, RD_WAIT} state_t;
  state_t                  r_state, w_state_nx;
  logic                    r_owner, w_owner_nx;
  logic [CW-1:0]           r_beat_cnt, r_beat_tot, r_rsp_cnt, r_rsp_tot;
  logic [CW-1:0]           w_beat_cnt_nx, w_beat_tot_nx, w_rsp_cnt_nx, w_rsp_tot_nx;
  logic                    w_req0, w_req1, w_rd, w_wr, w_fwd, w_done, w_tie;
  logic [BURSTCOUNT_W-1:0] w_bc;
  logic [CW-1:0]           w_bc_ext;
  assign w_req0   = avalon_h0.read | avalon_h0.write;
  assign w_req1   = avalon_h1.read | avalon_h1.write;
  assign w_rd     = r_owner ? avalon_h1.read : avalon_h0.read;
  assign w_wr     = r_owner ? avalon_h1.write : avalon_h0.write;
  assign w_bc     = r_owner ? avalon_h1.burstcount : avalon_h0.burstcount;
  assign w_bc_ext = CW'(w_bc);
  // Commands pass through only while the owner holds the bus; RD_WAIT and IDLE
  // present a quiet single-beat bus.
  assign w_fwd    = (r_state == GRANT) || (r_state == WR_BURST);
  assign avalon_m.address    = w_fwd ? (r_owner ? avalon_h1.address : avalon_h0.address) : '0;
  assign avalon_m.writedata  = w_fwd ? (r_owner ? avalon_h1.writedata : avalon_h0.writedata) : '0;
  assign avalon_m.byteenable = w_fwd ? (r_owner ? avalon_h1.byteenable : avalon_h0.byteenable) : '0;
  assign avalon_m.burstcount = w_fwd ? w_bc : BURSTCOUNT_W'(1);
  assign avalon_m.read       = w_fwd & w_rd;
  assign avalon_m.write      = w_fwd & w_wr;
  assign avalon_h0.waitrequest   = !(w_fwd && !r_owner) || avalon_m.waitrequest;
  assign avalon_h1.waitrequest   = !(w_fwd && r_owner) || avalon_m.waitrequest;
  assign avalon_h0.readdatavalid = (r_state == RD_WAIT) && !r_owner && avalon_m.readdatavalid;
  assign avalon_h1.readdatavalid = (r_state == RD_WAIT) && r_owner && avalon_m.readdatavalid;
  assign avalon_h0.readdata      = avalon_m.readdata;
  assign avalon_h1.readdata      = avalon_m.readdata;
`ifdef AVALON_ARB_FIXED_PRIO_EN
  assign w_tie = 1'b0;
`else
  logic r_last_owner;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last_owner <= 1'b1;
    else if (w_done) r_last_owner <= r_owner;
  assign w_tie = !r_last_owner;
`endif
  always_comb begin
    w_state_nx    = r_state;
    w_owner_nx    = r_owner;
    w_beat_cnt_nx = r_beat_cnt;
    w_beat_tot_nx = r_beat_tot;
    w_rsp_cnt_nx  = r_rsp_cnt;
    w_rsp_tot_nx  = r_rsp_tot;
    w_done        = 1'b0;
    case (r_state)
      IDLE: if (w_req0 || w_req1) begin
        w_state_nx = GRANT;
        w_owner_nx = (w_req0 && w_req1) ? w_tie : w_req1;
      end
      // A request withdrawn before acceptance releases the bus without
      // counting as a completed turn.
      GRANT: if (!(w_rd || w_wr)) w_state_nx = IDLE;
      else if (!avalon_m.waitrequest) begin
        if (!w_wr) begin
          w_state_nx   = RD_WAIT;
          w_rsp_cnt_nx = '0;
          w_rsp_tot_nx = (w_bc_ext == '0) ? CW'(1) : w_bc_ext;
        end else if (w_bc_ext <= CW'(1)) begin
          w_state_nx = IDLE;
          w_done     = 1'b1;
        end else begin
          w_state_nx    = WR_BURST;
          w_beat_cnt_nx = CW'(1);
          w_beat_tot_nx = w_bc_ext;
        end
      end
      WR_BURST: if (w_wr && !avalon_m.waitrequest) begin
        w_beat_cnt_nx = r_beat_cnt + CW'(1);
        if (r_beat_cnt + CW'(1) == r_beat_tot) begin
          w_state_nx = IDLE;
          w_done     = 1'b1;
        end
      end
      RD_WAIT: if (avalon_m.readdatavalid) begin
        w_rsp_cnt_nx = r_rsp_cnt + CW'(1);
        if (r_rsp_cnt + CW'(1) == r_rsp_tot) begin
          w_state_nx = IDLE;
          w_done     = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_beat_cnt <= '0;
      r_beat_tot <= '0;
      r_rsp_cnt  <= '0;
      r_rsp_tot  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_beat_cnt <= w_beat_cnt_nx;
      r_beat_tot <= w_beat_tot_nx;
      r_rsp_cnt  <= w_rsp_cnt_nx;
      r_rsp_tot  <= w_rsp_tot_nx;
    end
endmodule

// File: tb/tb_avalon_arbiter.sv
// tb_avalon_arbiter: scoreboard bench for avalon_arbiter with a RAM agent model.
module tb_avalon_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  avalon_if #(.BURSTCOUNT_W(4)) h0_if (.clk(clk), .reset(reset));
  avalon_if #(.BURSTCOUNT_W(4)) h1_if (.clk(clk), .reset(reset));
  avalon_if #(.BURSTCOUNT_W(4)) m_if (.clk(clk), .reset(reset));
  avalon_arbiter #(.BURSTCOUNT_W(4)) dut (
    .clk(clk), .reset(reset), .avalon_h0(h0_if), .avalon_h1(h1_if), .avalon_m(m_if)
  );
  logic [31:0] h_addr[2], h_wdata[2];
  logic [3:0]  h_bc[2];
  logic        h_rd[2], h_wr[2];
  assign h0_if.address = h_addr[0];
  assign h0_if.writedata = h_wdata[0];
  assign h0_if.byteenable = 4'hF;
  assign h0_if.burstcount = h_bc[0];
  assign h0_if.read = h_rd[0];
  assign h0_if.write = h_wr[0];
  assign h1_if.address = h_addr[1];
  assign h1_if.writedata = h_wdata[1];
  assign h1_if.byteenable = 4'hF;
  assign h1_if.burstcount = h_bc[1];
  assign h1_if.read = h_rd[1];
  assign h1_if.write = h_wr[1];
  logic        m_wait = 1'b1, m_rdv = 1'b0;
  logic [31:0] m_rdata = '0;
  assign m_if.waitrequest = m_wait;
  assign m_if.readdatavalid = m_rdv;
  assign m_if.readdata = m_rdata;
  logic [31:0] ram[int];
  logic [31:0] ref_mem[int];
  logic [31:0] rsp_q[$];
  logic [31:0] exp_q0[$], exp_q1[$];
  int          grant_log[$], exp_g[$];
  int          wr_beat = 0, wr_tot = 0, wr_base = 0;
  int          n_rdv[2] = '{0, 0};
  int          n_tests = 0, n_fail = 0;
  int          model_last = 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ram_rd(input int k);
    return ram.exists(k) ? ram[k] : 32'h0;
  endfunction
  function automatic logic [31:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction
  function automatic logic hw(input int h);
    return h != 0 ? h1_if.waitrequest : h0_if.waitrequest;
  endfunction
  function automatic int tie_winner(input int last);
`ifdef AVALON_ARB_FIXED_PRIO_EN
    return last & 0;
`else
    return 1 - last;
`endif
  endfunction
  // RAM agent: random stalls, random response gaps, burst address increments.
  always @(negedge clk) begin
    if (reset) begin
      m_wait = 1'b1;
      m_rdv = 1'b0;
      rsp_q.delete();
      wr_beat = 0;
    end else begin
      m_wait = ($urandom_range(0, 3) == 0);
      m_rdv = (rsp_q.size() > 0) && ($urandom_range(0, 3) != 0);
      if (m_rdv) m_rdata = rsp_q.pop_front();
      else m_rdata = $urandom;
      #2;
      if (!reset) begin
        chk("single_owner", 32'(!h0_if.waitrequest && !h1_if.waitrequest), 0);
        if (m_rdv || rsp_q.size() > 0) chk("no_cmd_while_rsp_pending", {30'b0, m_if.read, m_if.write}, 0);
        if (!m_wait && (m_if.read || m_if.write)) begin
          if (m_if.write) begin
            if (wr_beat == 0) begin
              wr_base = int'(m_if.address >> 2);
              wr_tot = (m_if.burstcount == 0) ? 1 : int'(m_if.burstcount);
              grant_log.push_back(h0_if.waitrequest ? 1 : 0);
            end
            ram[wr_base + wr_beat] = m_if.writedata;
            wr_beat = (wr_beat + 1 == wr_tot) ? 0 : wr_beat + 1;
          end else begin
            grant_log.push_back(h0_if.waitrequest ? 1 : 0);
            for (int i = 0; i < ((m_if.burstcount == 0) ? 1 : int'(m_if.burstcount)); i++)
              rsp_q.push_back(ram_rd(int'(m_if.address >> 2) + i));
          end
        end
      end
    end
  end
  // Response monitor: pops the per-host scoreboard on every readdatavalid.
  always @(negedge clk) begin
    #3;
    if (!reset) begin
      if (h0_if.readdatavalid) begin
        n_rdv[0]++;
        if (exp_q0.size() == 0) chk("h0_rdv_unexpected", 32'(h0_if.readdatavalid), 0);
        else chk("h0_readdata", h0_if.readdata, exp_q0.pop_front());
      end
      if (h1_if.readdatavalid) begin
        n_rdv[1]++;
        if (exp_q1.size() == 0) chk("h1_rdv_unexpected", 32'(h1_if.readdatavalid), 0);
        else chk("h1_readdata", h1_if.readdata, exp_q1.pop_front());
      end
      if (m_rdv) chk("rdv_routed", 32'(h0_if.readdatavalid | h1_if.readdatavalid), 1);
    end
  end
  task automatic wait_accept(input int h);
    int  t = 0;
    bit  done = 0;
    while (!done) begin
      #2;
      done = !hw(h);
      @(negedge clk);
      if (!done && ++t > 1000) begin
        chk("accept_timeout", 32'(t), 0);
        done = 1;
      end
    end
  endtask
  task automatic host_write(input int h, input logic [31:0] a, input int bc, input int gap, input logic [31:0] d0);
    int          n = (bc == 0) ? 1 : bc;
    logic [31:0] d[$];
    for (int i = 0; i < n; i++) begin
      d.push_back(i == 0 ? d0 : $urandom);
      ref_mem[int'(a >> 2) + i] = d[i];
    end
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        h_wr[h] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      h_addr[h] = a;
      h_wdata[h] = d[i];
      h_bc[h] = 4'(bc);
      h_wr[h] = 1'b1;
      wait_accept(h);
    end
    h_wr[h] = 1'b0;
  endtask
  task automatic host_read(input int h, input logic [31:0] a, input int bc);
    for (int i = 0; i < ((bc == 0) ? 1 : bc); i++)
      if (h == 0) exp_q0.push_back(ref_rd(int'(a >> 2) + i));
      else exp_q1.push_back(ref_rd(int'(a >> 2) + i));
    h_addr[h] = a;
    h_bc[h] = 4'(bc);
    h_rd[h] = 1'b1;
    wait_accept(h);
    h_rd[h] = 1'b0;
  endtask
  task automatic wait_quiet();
    int t = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0 || rsp_q.size() > 0 || m_rdv) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("quiet_timeout", 32'(exp_q0.size() + exp_q1.size() + rsp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_h0_wait", 32'(h0_if.waitrequest), 1);
    chk("rst_h1_wait", 32'(h1_if.waitrequest), 1);
    chk("rst_h0_rdv", 32'(h0_if.readdatavalid), 0);
    chk("rst_h1_rdv", 32'(h1_if.readdatavalid), 0);
    chk("rst_m_rw", {30'b0, m_if.read, m_if.write}, 0);
    chk("rst_m_burstcount", 32'(m_if.burstcount), 1);
    chk("rst_m_address", m_if.address, 0);
    chk("rst_m_writedata", m_if.writedata, 0);
    chk("rst_m_byteenable", 32'(m_if.byteenable), 0);
    exp_q0.delete();
    exp_q1.delete();
    grant_log.delete();
    model_last = 1;
    repeat (2) @(negedge clk);
    #4 reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic chk_grants(input string name);
    chk({name, "_count"}, 32'(grant_log.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++) chk(name, 32'(grant_log[i]), 32'(exp_g[i]));
    grant_log.delete();
    exp_g.delete();
  endtask
  // Abstract arbitration model for hosts issuing back-to-back single reads.
  task automatic model_contend(input int c0, input int c1);
    int w;
    exp_g.delete();
    while (c0 + c1 > 0) begin
      w = (c0 > 0 && c1 > 0) ? tie_winner(model_last) : (c0 > 0 ? 0 : 1);
      exp_g.push_back(w);
      if (w == 0) c0--;
      else c1--;
      model_last = w;
    end
  endtask
  task automatic contend(input string name, input int c0, input int c1);
    model_contend(c0, c1);
    fork
      for (int i = 0; i < c0; i++) host_read(0, 32'h1000 + 32'(i * 4), 1);
      for (int i = 0; i < c1; i++) host_read(1, 32'h2000 + 32'(i * 4), 1);
    join
    wait_quiet();
    chk_grants(name);
  endtask
  task automatic rand_ops(input int h);
    logic [31:0] a;
    int          bc;
    for (int i = 0; i < 15; i++) begin
      a = (h == 0 ? 32'h3000 : 32'h4000) + 32'($urandom_range(0, 7) * 64);
      bc = $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 1) host_write(h, a, bc, $urandom_range(0, 2), $urandom);
      else host_read(h, a, bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  initial begin
    int b0, b1, t;
    for (int i = 0; i < 2; i++) begin
      h_addr[i] = '0;
      h_wdata[i] = '0;
      h_bc[i] = 4'd1;
      h_rd[i] = 1'b0;
      h_wr[i] = 1'b0;
    end
    @(negedge clk);
    #4;
    do_reset();
    b0 = n_rdv[0];
    b1 = n_rdv[1];
    host_write(0, 32'h10, 1, 0, 32'hDEADBEEF);
    host_read(1, 32'h10, 1);
    wait_quiet();
    chk("h1_single_rdv", 32'(n_rdv[1] - b1), 1);
    chk("h0_no_rdv", 32'(n_rdv[0] - b0), 0);
    exp_g.push_back(0);
    exp_g.push_back(1);
    chk_grants("wr_then_rd_grants");
    @(negedge clk);
    #4;
    do_reset();
    contend("tie_pair1", 1, 1);
    contend("tie_pair2", 1, 1);
    contend("continuous", 3, 3);
    fork
      host_write(0, 32'h40, 4, 2, $urandom);
      begin
        @(negedge clk);
        host_read(1, 32'h40, 4);
      end
    join
    wait_quiet();
    exp_g.push_back(0);
    exp_g.push_back(1);
    chk_grants("burst_grants");
    model_last = 1;
    host_write(1, 32'h2000, 8, 0, $urandom);
    wait_quiet();
    grant_log.delete();
    b0 = n_rdv[0];
    b1 = n_rdv[1];
    fork
      host_read(1, 32'h2000, 8);
      begin
        @(negedge clk);
        host_write(0, 32'h1100, 1, 0, 32'h12345678);
      end
    join
    wait_quiet();
    chk("h1_rd8_rdv", 32'(n_rdv[1] - b1), 8);
    chk("h0_rd8_no_rdv", 32'(n_rdv[0] - b0), 0);
    exp_g.push_back(1);
    exp_g.push_back(0);
    chk_grants("rd8_grants");
    b0 = n_rdv[0];
    host_read(0, 32'h40, 4);
    t = 0;
    do begin
      @(negedge clk);
      #4;
      t++;
    end while (n_rdv[0] - b0 < 2 && t < 500);
    chk("mid_read_beats", 32'(n_rdv[0] - b0), 2);
    do_reset();
    b0 = n_rdv[0];
    host_read(0, 32'h40, 1);
    wait_quiet();
    chk("post_reset_rdv", 32'(n_rdv[0] - b0), 1);
    exp_g.push_back(0);
    chk_grants("post_reset_grants");
    fork
      rand_ops(0);
      rand_ops(1);
    join
    wait_quiet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
